// File: rtl/spi_cmd_sequencer.sv
// Command sequencer: buffers SPI words in a small FIFO, parses header+argument
// commands and hands each one to the line, clear or swap unit, one at a time.
module spi_cmd_sequencer #(
  parameter int CORDW      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_word_valid,
  input  logic [15:0]      io_word,
  output logic             io_line_start,
  output logic [CORDW-1:0] io_x0,
  output logic [CORDW-1:0] io_y0,
  output logic [CORDW-1:0] io_x1,
  output logic [CORDW-1:0] io_y1,
  input  logic             io_line_done,
  output logic             io_clear_start,
  output logic [15:0]      io_clear_color,
  input  logic             io_clear_done,
  output logic             io_swap_req,
  input  logic             io_swap_ack,
  output logic             io_overflow,
  output logic             io_bad_opcode,
  output logic             io_idle
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LINE  = 4'h1;
  localparam logic [3:0] OP_CLEAR = 4'h2;
  localparam logic [3:0] OP_SWAP  = 4'h3;

  typedef enum logic [1:0] {S_HEADER, S_ARGS, S_DISPATCH, S_WAIT} state_t;
  typedef enum logic [1:0] {C_NONE, C_LINE, C_CLEAR, C_SWAP} cmd_t;

  logic [15:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [15:0]      w_head;

  state_t           r_state;
  cmd_t             r_cmd;
  logic [1:0]       r_arg_cnt;
  logic [CORDW-1:0] r_arg [4];
  logic [15:0]      r_clear_color;
  logic             r_line_start;
  logic             r_clear_start;
  logic             r_swap_req;
  logic             r_overflow;
  logic             r_bad_opcode;

  // Push is judged on the registered count only, so a same-cycle pop never frees room.
  assign w_empty = (r_count == {(AW+1){1'b0}});
  assign w_push  = io_word_valid && (r_count < DEPTH_C);
  assign w_pop   = ((r_state == S_HEADER) || (r_state == S_ARGS)) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];

  // Occupancy update from the push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + {{AW{1'b0}}, 1'b1};
      2'b01:   w_count_nxt = r_count - {{AW{1'b0}}, 1'b1};
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_word;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {(AW+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      if (io_word_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Command parser and dispatcher; start strobes are set on entry to DISPATCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_HEADER;
      r_cmd         <= C_NONE;
      r_arg_cnt     <= 2'd0;
      r_arg[0]      <= {CORDW{1'b0}};
      r_arg[1]      <= {CORDW{1'b0}};
      r_arg[2]      <= {CORDW{1'b0}};
      r_arg[3]      <= {CORDW{1'b0}};
      r_clear_color <= 16'h0000;
      r_line_start  <= 1'b0;
      r_clear_start <= 1'b0;
      r_swap_req    <= 1'b0;
      r_bad_opcode  <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_clear_start <= 1'b0;
      case (r_state)
        S_HEADER: begin
          if (w_pop) begin
            case (w_head[15:12])
              OP_NOP: r_cmd <= C_NONE;
              OP_LINE: begin
                r_cmd     <= C_LINE;
                r_arg_cnt <= 2'd0;
                r_state   <= S_ARGS;
              end
              OP_CLEAR: begin
                r_cmd     <= C_CLEAR;
                r_arg_cnt <= 2'd0;
                r_state   <= S_ARGS;
              end
              OP_SWAP: begin
                r_cmd      <= C_SWAP;
                r_swap_req <= 1'b1;
                r_state    <= S_DISPATCH;
              end
              default: r_bad_opcode <= 1'b1;
            endcase
          end
        end
        S_ARGS: begin
          if (w_pop) begin
            if (r_cmd == C_CLEAR) begin
              r_clear_color <= w_head;
              r_clear_start <= 1'b1;
              r_state       <= S_DISPATCH;
            end else begin
              r_arg[r_arg_cnt] <= w_head[CORDW-1:0];
              r_arg_cnt        <= r_arg_cnt + 2'd1;
              if (r_arg_cnt == 2'd3) begin
                r_line_start <= 1'b1;
                r_state      <= S_DISPATCH;
              end
            end
          end
        end
        S_DISPATCH: r_state <= S_WAIT;
        S_WAIT: begin
          case (r_cmd)
            C_LINE:  if (io_line_done)  r_state <= S_HEADER;
            C_CLEAR: if (io_clear_done) r_state <= S_HEADER;
            C_SWAP: begin
              if (io_swap_ack) begin
                r_swap_req <= 1'b0;
                r_state    <= S_HEADER;
              end
            end
            default: r_state <= S_HEADER;
          endcase
        end
        default: r_state <= S_HEADER;
      endcase
    end
  end

  assign io_line_start  = r_line_start;
  assign io_x0          = r_arg[0];
  assign io_y0          = r_arg[1];
  assign io_x1          = r_arg[2];
  assign io_y1          = r_arg[3];
  assign io_clear_start = r_clear_start;
  assign io_clear_color = r_clear_color;
  assign io_swap_req    = r_swap_req;
  assign io_overflow    = r_overflow;
  assign io_bad_opcode  = r_bad_opcode;
  assign io_idle        = (r_state == S_HEADER) && w_empty;

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Sits between the SPI slave word deserializer and the raster engines inside Main.
- Buffers incoming 16-bit words from the MCU in a small FIFO and parses them into commands (header word plus arguments).
- Dispatches each command to the line drawer, the framebuffer clear unit or the buffer swap logic, then waits for that unit's completion handshake before parsing the next header.
- Commands may arrive while a draw is still running.

Parameters:
- CORDW, 16, coordinate width; must equal word width 16.
- FIFO_DEPTH, 8, word FIFO entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_word_valid  in  1  one-cycle strobe, new SPI word (already in clock domain)
- io_word  in  16  received word
- io_line_start  out  1  one-cycle pulse, start line draw
- io_x0, io_y0, io_x1, io_y1  out  CORDW each  line endpoints, held from start until done
- io_line_done  in  1  one-cycle pulse from line drawer
- io_clear_start  out  1  one-cycle pulse, start framebuffer clear
- io_clear_color  out  16  clear colour, held from start until done
- io_clear_done  in  1  clear finished pulse
- io_swap_req  out  1  level, request buffer swap; held until ack
- io_swap_ack  in  1  swap accepted pulse
- io_overflow  out  1  sticky, a word was dropped because the FIFO was full
- io_bad_opcode  out  1  sticky, an unknown header was received
- io_idle  out  1  high when state is HEADER and the FIFO is empty

Behaviour:
- Reset state:
  - All outputs 0, except io_idle = 1.
  - FIFO is empty; state is HEADER; argument registers are 0.
  - The sticky flags are cleared only by reset.
- FIFO push: occurs on io_word_valid when the registered count is below FIFO_DEPTH.
- FIFO overflow:
  - If io_word_valid arrives with count == FIFO_DEPTH, the word is dropped and io_overflow is set.
  - A pop in the same cycle does not free a slot for that push.
- Simultaneous push and pop when not full: count is unchanged; both take effect.
- FIFO visibility: a word pushed in cycle N is visible to the parser in cycle N+1.
- Pop rule: the parser pops at most one word per cycle, only in HEADER or ARGS, only when the FIFO is not empty.
- Header format: opcode = word[15:12]; word[11:0] is ignored.
  - 0x0 NOP: 0 arguments.
  - 0x1 LINE: 4 arguments, in order x0, y0, x1, y1.
  - 0x2 CLEAR: 1 argument, colour.
  - 0x3 SWAP: 0 arguments.
  - All other opcodes: set io_bad_opcode, discard the word, stay in HEADER.
- States:
  - HEADER: pop the header.
    - NOP stays in HEADER.
    - SWAP goes to DISPATCH.
    - LINE and CLEAR go to ARGS with the argument counter at 0.
  - ARGS: each pop stores the word into the argument register at the counter index and increments the counter.
    - Popping the last argument goes to DISPATCH.
    - An empty FIFO stalls ARGS indefinitely; there is no timeout.
  - DISPATCH: lasts exactly one cycle.
    - LINE or CLEAR: the matching start output is high for this cycle.
    - SWAP: io_swap_req rises.
    - Next state is WAIT.
  - WAIT: hold all argument outputs.
    - On the done or ack pulse matching the active command, go to HEADER.
    - io_swap_req falls in the cycle after io_swap_ack.
    - Non-matching done or ack pulses are ignored.
- Done and ack pulses that arrive during DISPATCH are ignored; the target must respond no earlier than the cycle after start.
- Latency: the start pulse occurs in the cycle after the last argument is popped. Minimum timing for a LINE whose 5 words are already in the FIFO is:
  - header pop in cycle 0;
  - argument pops in cycles 1–4;
  - io_line_start in cycle 5.
- Back-to-back commands: the FIFO keeps accepting words during WAIT. The next header is popped in the cycle after the return to HEADER.
- Reset mid-command: any state returns to HEADER, the FIFO is flushed, and start and request outputs are deasserted in the next cycle.

Test Plan:
- LINE: push 0x1000, 0, 0, 100, 100 at SPI rate.
  - Expect one io_line_start pulse with x0=0, y0=0, x1=100, y1=100.
  - io_idle=0 until io_line_done, then io_idle=1.
- CLEAR then SWAP: push 0x2000, 0xF800, 0x3000.
  - Expect io_clear_start with colour 0xF800.
  - After io_clear_done, expect io_swap_req high.
  - io_swap_req falls the cycle after io_swap_ack.
- Back-to-back LINEs: push two LINE commands (10 words) while io_line_done is withheld for 200 cycles.
  - Expect no overflow.
  - The second io_line_start occurs 6 cycles after the first io_line_done, with the second set of coordinates.
- Overflow: hold io_line_done low and push FIFO_DEPTH+6 words.
  - Expect io_overflow=1 on the first dropped word.
  - Expect exactly FIFO_DEPTH words to be retained after the parser's pops.
- Bad opcode: push 0x7ABC, then the NOP header 0x0000, then a valid LINE.
  - Expect io_bad_opcode=1 with no start pulses for the bad word or the NOP.
  - The LINE dispatches normally.
- Reset mid-ARGS: push 0x1000, 5, 6, then assert reset for 1 cycle, then push a full LINE with 1, 2, 3, 4.
  - Expect a single io_line_start with (1, 2, 3, 4).
  - Expect io_overflow=0 and io_bad_opcode=0.
